// File: rtl/norm_arbiter_if.sv
// Bundle of the two request ports, the shared-shifter hookup and the result port of norm_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/shifter/consumer side.
interface norm_arbiter_if #(
    parameter int MANT_W   = 24,
    parameter int SH_W     = 5,
    parameter int EXP_IN_W = 10,
    parameter int EXP_W    = 8
);
    logic                req0_valid;
    logic                req0_ready;
    logic [MANT_W-1:0]   req0_mant;
    logic [EXP_IN_W-1:0] req0_exp;

    logic                req1_valid;
    logic                req1_ready;
    logic [MANT_W-1:0]   req1_mant;
    logic [EXP_IN_W-1:0] req1_exp;

    logic [MANT_W-1:0]   sh_in;
    logic [SH_W-1:0]     sh_amt;
    logic [MANT_W-1:0]   sh_out;

    logic                out_valid;
    logic                out_ready;
    logic                out_id;
    logic [MANT_W-1:0]   out_mant;
    logic [EXP_W-1:0]    out_exp;
    logic                out_zero;
    logic                out_unf;
    logic                out_ovf;

    modport slave (
        input  req0_valid, req0_mant, req0_exp,
        output req0_ready,
        input  req1_valid, req1_mant, req1_exp,
        output req1_ready,
        output sh_in, sh_amt,
        input  sh_out,
        output out_valid, out_id, out_mant, out_exp, out_zero, out_unf, out_ovf,
        input  out_ready
    );

    modport master (
        output req0_valid, req0_mant, req0_exp,
        input  req0_ready,
        output req1_valid, req1_mant, req1_exp,
        input  req1_ready,
        input  sh_in, sh_amt,
        output sh_out,
        input  out_valid, out_id, out_mant, out_exp, out_zero, out_unf, out_ovf,
        output out_ready
    );
endinterface

// File: rtl/norm_arbiter.sv
// Round-robin sequencer for the shared mantissa-normalization shifter: grants divider/multiplier
// requests, drives the external shifter with the leading-zero count and returns a flagged result.
module norm_arbiter #(
    parameter int MANT_W   = 24,
    parameter int SH_W     = 5,
    parameter int EXP_IN_W = 10,
    parameter int EXP_W    = 8
) (
    input logic         clk,
    input logic         rst,
    norm_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT
    } state_t;

    localparam logic signed [EXP_IN_W:0] EXP_ZERO = '0;
    localparam logic signed [EXP_IN_W:0] EXP_MAX  = (EXP_IN_W+1)'((1 << EXP_W) - 1);

    state_t               r_state;
    state_t               w_nextState;

    logic                 r_lastGrant;
    logic [MANT_W-1:0]    r_mant;
    logic [EXP_IN_W-1:0]  r_exp;
    logic                 r_id;

    logic [MANT_W-1:0]    r_outMant;
    logic [EXP_W-1:0]     r_outExp;
    logic                 r_outId;
    logic                 r_outZero;
    logic                 r_outUnf;
    logic                 r_outOvf;

    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_capture;
    logic                 w_load;
    logic                 w_outValid;
    logic [MANT_W-1:0]    w_shIn;
    logic [SH_W-1:0]      w_shAmt;
    logic [SH_W-1:0]      w_lzc;
    logic signed [EXP_IN_W:0] w_expAdj;

    // An all-zero mantissa reports a count of 0 so the shifter sees a harmless amount.
    function automatic logic [SH_W-1:0] leadingZeros(input logic [MANT_W-1:0] mant);
        logic [SH_W-1:0] count;
        logic            found;
        count = '0;
        found = 1'b0;
        for (int i = MANT_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (mant[i]) begin
                    found = 1'b1;
                end else begin
                    count = count + 1'b1;
                end
            end
        end
        if (!found) begin
            count = '0;
        end
        return count;
    endfunction

    assign w_lzc    = leadingZeros(r_mant);
    assign w_expAdj = $signed({r_exp[EXP_IN_W-1], r_exp})
                    - $signed({{(EXP_IN_W + 1 - SH_W){1'b0}}, w_lzc});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_capture   = 1'b0;
        w_load      = 1'b0;
        w_outValid  = 1'b0;
        w_shIn      = '0;
        w_shAmt     = '0;
        case (r_state)
            IDLE: begin
                // On a tie the requester that did not win last time goes first.
                if (bus.req0_valid && bus.req1_valid) begin
                    w_grant0 = r_lastGrant;
                    w_grant1 = ~r_lastGrant;
                end else begin
                    w_grant0 = bus.req0_valid;
                    w_grant1 = bus.req1_valid;
                end
                if (w_grant0 || w_grant1) begin
                    w_capture   = 1'b1;
                    w_nextState = CALC;
                end
            end
            CALC: begin
                w_shIn      = r_mant;
                w_shAmt     = w_lzc;
                w_load      = 1'b1;
                w_nextState = OUT;
            end
            OUT: begin
                w_outValid = 1'b1;
                if (bus.out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastGrant <= 1'b1;
            r_mant      <= '0;
            r_exp       <= '0;
            r_id        <= 1'b0;
            r_outMant   <= '0;
            r_outExp    <= '0;
            r_outId     <= 1'b0;
            r_outZero   <= 1'b0;
            r_outUnf    <= 1'b0;
            r_outOvf    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_mant      <= w_grant1 ? bus.req1_mant : bus.req0_mant;
                r_exp       <= w_grant1 ? bus.req1_exp  : bus.req0_exp;
                r_id        <= w_grant1;
                r_lastGrant <= w_grant1;
            end
            if (w_load) begin
                r_outId   <= r_id;
                r_outZero <= 1'b0;
                r_outUnf  <= 1'b0;
                r_outOvf  <= 1'b0;
                if (r_mant == '0) begin
                    r_outZero <= 1'b1;
                    r_outMant <= '0;
                    r_outExp  <= '0;
                end else if (w_expAdj <= EXP_ZERO) begin
                    r_outUnf  <= 1'b1;
                    r_outMant <= '0;
                    r_outExp  <= '0;
                end else if (w_expAdj >= EXP_MAX) begin
                    r_outOvf  <= 1'b1;
                    r_outMant <= '0;
                    r_outExp  <= '1;
                end else begin
                    r_outMant <= bus.sh_out;
                    r_outExp  <= w_expAdj[EXP_W-1:0];
                end
            end
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.sh_in      = w_shIn;
    assign bus.sh_amt     = w_shAmt;
    assign bus.out_valid  = w_outValid;
    assign bus.out_id     = r_outId;
    assign bus.out_mant   = r_outMant;
    assign bus.out_exp    = r_outExp;
    assign bus.out_zero   = r_outZero;
    assign bus.out_unf    = r_outUnf;
    assign bus.out_ovf    = r_outOvf;

endmodule
